// File: rtl/vga_pkg.sv
// Shared VGA timing constants, coordinate width and renderer colour constants.
// Colours are 8-bit BGR packed as {B[1:0], G[2:0], R[2:0]}.
package vga_pkg;

    localparam int COORD_W   = 11;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [7:0] COL_BLACK  = 8'h00;
    localparam logic [7:0] COL_GREEN  = 8'h38;
    localparam logic [7:0] COL_YELLOW = 8'h3F;
    localparam logic [7:0] COL_BLUE   = 8'hC0;

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-rate divider: o_tick is the combinational terminal count used to advance
// the counters, o_pix_en is the registered one-clk pulse on that same edge.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick,
    output logic o_pix_en
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_pix_en;
    logic          w_tc;

    assign w_tc = (r_cnt == TC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_cnt    <= w_tc ? '0 : r_cnt + 1'b1;
            r_pix_en <= w_tc;
        end
    end

    assign o_tick   = w_tc;
    assign o_pix_en = r_pix_en;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel coordinates, active-low syncs, blanking and frame pulse.
// Sync/blank flags are decoded from the next-state coordinates so they line up with xCoord/yCoord.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        pix_en,
    output logic [vga_pkg::COORD_W-1:0] xCoord,
    output logic [vga_pkg::COORD_W-1:0] yCoord,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        video_on,
    output logic                        frame_start
);

    import vga_pkg::*;

    localparam logic [COORD_W-1:0] HT       = COORD_W'(H_VISIBLE + H_FP + H_SYNC + H_BP);
    localparam logic [COORD_W-1:0] VT       = COORD_W'(V_VISIBLE + V_FP + V_SYNC + V_BP);
    localparam logic [COORD_W-1:0] HV       = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] VV       = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;
    logic               r_frame_start;

    logic               w_tick;
    logic               w_pix_en;
    logic               w_x_wrap;
    logic               w_y_wrap;
    logic [COORD_W-1:0] w_x_next;
    logic [COORD_W-1:0] w_y_next;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .o_tick   (w_tick),
        .o_pix_en (w_pix_en)
    );

    assign w_x_wrap = (r_x == HT - 11'd1);
    assign w_y_wrap = (r_y == VT - 11'd1);
    assign w_x_next = w_x_wrap ? '0 : r_x + 11'd1;
    // y only moves on the x wrap, so x and y can never step independently
    assign w_y_next = !w_x_wrap ? r_y : (w_y_wrap ? '0 : r_y + 11'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_tick) begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hsync       <= !((w_x_next >= HS_START) && (w_x_next <= HS_END));
            r_vsync       <= !((w_y_next >= VS_START) && (w_y_next <= VS_END));
            r_video_on    <= (w_x_next < HV) && (w_y_next < VV);
            r_frame_start <= w_x_wrap && w_y_wrap;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign pix_en      = w_pix_en;
    assign xCoord      = r_x;
    assign yCoord      = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default timing at CLK_DIV=4 and 1, plus a shrunken timing for whole-frame checks.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_m_n, rst_o_n, rst_s_n;
    logic        m_pix, m_hs, m_vs, m_von, m_fs;
    logic [10:0] m_x, m_y;
    logic        o_pix, o_hs, o_vs, o_von, o_fs;
    logic [10:0] o_x, o_y;
    logic        s_pix, s_hs, s_vs, s_von, s_fs;
    logic [10:0] s_x, s_y;

    int checks = 0;
    int errors = 0;

    vga_sync_gen #(.CLK_DIV(4)) u_main (
        .clk(clk), .rst_n(rst_m_n), .pix_en(m_pix), .xCoord(m_x), .yCoord(m_y),
        .hsync(m_hs), .vsync(m_vs), .video_on(m_von), .frame_start(m_fs)
    );

    vga_sync_gen #(.CLK_DIV(1)) u_one (
        .clk(clk), .rst_n(rst_o_n), .pix_en(o_pix), .xCoord(o_x), .yCoord(o_y),
        .hsync(o_hs), .vsync(o_vs), .video_on(o_von), .frame_start(o_fs)
    );

    // 23 x 13 frame: hsync x=18..20, vsync y=10..11, visible 16 x 8
    vga_sync_gen #(
        .CLK_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .clk(clk), .rst_n(rst_s_n), .pix_en(s_pix), .xCoord(s_x), .yCoord(s_y),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .frame_start(s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int pe_early, fs_cnt, hs_low, hs_first, wrap_seen, y_at_wrap, skew, found;
        int pz, w1, w2, first_pix, first_x;
        int nfs, f1, f2, fs_pos, fs_wide, hs_err, vs_err, von_err, hold_err, vs_low;
        int c1, c2, c3, seen_tick;
        logic [10:0] px, py;
        logic prev_fs;

        rst_m_n = 1'b0; rst_o_n = 1'b0; rst_s_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", m_x, 0);
        chk("rst_y", m_y, 0);
        chk("rst_pix_en", m_pix, 0);
        chk("rst_hsync", m_hs, 1);
        chk("rst_vsync", m_vs, 1);
        chk("rst_video_on", m_von, 0);
        chk("rst_frame_start", m_fs, 0);

        // ---- CLK_DIV=4: first pixel tick
        rst_m_n = 1'b1;
        pe_early = 0; fs_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_pix) pe_early++;
            if (m_fs) fs_cnt++;
        end
        chk("pix_en_early", pe_early, 0);
        @(negedge clk);
        chk("first_pix_en", m_pix, 1);
        chk("first_x", m_x, 1);
        chk("first_y", m_y, 0);
        chk("first_hsync", m_hs, 1);
        chk("first_video_on", m_von, 1);
        @(negedge clk);
        chk("pix_en_width", m_pix, 0);
        chk("x_hold", m_x, 1);

        // ---- one full line
        hs_low = 0; hs_first = -1; wrap_seen = 0; y_at_wrap = -1; skew = 0;
        px = m_x; py = m_y;
        for (int i = 0; i < 4000 && wrap_seen == 0; i++) begin
            @(negedge clk);
            if (!m_hs) begin
                if (hs_first < 0) hs_first = int'(m_x);
                hs_low++;
            end
            if (m_fs) fs_cnt++;
            if (px == 11'd799 && m_x == 11'd0) begin
                wrap_seen = 1;
                y_at_wrap = int'(m_y);
            end else if (m_y != py) begin
                skew++;
            end
            px = m_x; py = m_y;
        end
        chk("line_wrap_seen", wrap_seen, 1);
        chk("y_on_x_wrap", y_at_wrap, 1);
        chk("y_skew", skew, 0);
        chk("hsync_low_clks", hs_low, 384);
        chk("hsync_first_x", hs_first, 656);
        chk("no_frame_start_line0", fs_cnt, 0);

        // ---- async reset mid-line, between ticks
        found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            @(negedge clk);
            if (m_x == 11'd400 && m_y == 11'd1 && !m_pix) found = 1;
        end
        chk("reach_400_1", found, 1);
        #1 rst_m_n = 1'b0;
        #1;
        chk("async_x", m_x, 0);
        chk("async_y", m_y, 0);
        chk("async_pix_en", m_pix, 0);
        chk("async_hsync", m_hs, 1);
        chk("async_vsync", m_vs, 1);
        chk("async_video_on", m_von, 0);
        chk("async_frame_start", m_fs, 0);
        @(negedge clk);
        rst_m_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("restart_pix_en", m_pix, 1);
        chk("restart_x", m_x, 1);
        chk("restart_y", m_y, 0);

        // ---- CLK_DIV=1: continuous ticks, 800-clk lines
        @(negedge clk);
        rst_o_n = 1'b1;
        pz = 0; w1 = 0; w2 = 0; hs_low = 0; hs_first = -1; first_pix = -1; first_x = -1;
        px = o_x;
        for (int i = 1; i <= 1700; i++) begin
            @(negedge clk);
            if (i == 1) begin
                first_pix = int'(o_pix);
                first_x = int'(o_x);
            end
            if (!o_pix) pz++;
            if (px == 11'd799 && o_x == 11'd0) begin
                if (w1 == 0) w1 = i;
                else if (w2 == 0) w2 = i;
            end
            if (w1 != 0 && w2 == 0 && !o_hs) begin
                if (hs_first < 0) hs_first = int'(o_x);
                hs_low++;
            end
            px = o_x;
        end
        chk("div1_first_pix_en", first_pix, 1);
        chk("div1_first_x", first_x, 1);
        chk("div1_pix_en_gaps", pz, 0);
        chk("div1_first_wrap", w1, 800);
        chk("div1_line_period", w2 - w1, 800);
        chk("div1_hsync_low", hs_low, 96);
        chk("div1_hsync_first_x", hs_first, 656);

        // ---- small timing, CLK_DIV=2: whole frames
        @(negedge clk);
        rst_s_n = 1'b1;
        nfs = 0; f1 = 0; f2 = 0; fs_pos = 0; fs_wide = 0;
        hs_err = 0; vs_err = 0; von_err = 0; hold_err = 0; vs_low = 0;
        c1 = -1; c2 = -1; c3 = -1; seen_tick = 0;
        px = s_x; py = s_y; prev_fs = 1'b0;
        for (int i = 1; i <= 1250; i++) begin
            @(negedge clk);
            if (s_pix) seen_tick = 1;
            if (s_fs) begin
                nfs++;
                if (f1 == 0) f1 = i;
                else if (f2 == 0) f2 = i;
                if (s_x != 11'd0 || s_y != 11'd0) fs_pos++;
                if (prev_fs) fs_wide++;
            end
            if (seen_tick != 0) begin
                if (s_hs !== !(s_x >= 11'd18 && s_x <= 11'd20)) hs_err++;
                if (s_vs !== !(s_y >= 11'd10 && s_y <= 11'd11)) vs_err++;
                if (s_von !== (s_x < 11'd16 && s_y < 11'd8)) von_err++;
            end
            if (!s_pix && (s_x != px || s_y != py)) hold_err++;
            if (f1 == 0 && !s_vs) vs_low++;
            if (s_x == 11'd15 && s_y == 11'd7) c1 = int'(s_von);
            if (s_x == 11'd16 && s_y == 11'd7) c2 = int'(s_von);
            if (s_x == 11'd15 && s_y == 11'd8) c3 = int'(s_von);
            px = s_x; py = s_y; prev_fs = s_fs;
        end
        chk("frame_start_count", nfs, 2);
        chk("frame_start_first", f1, 598);
        chk("frame_start_period", f2 - f1, 598);
        chk("frame_start_at_origin", fs_pos, 0);
        chk("frame_start_width", fs_wide, 0);
        chk("small_hsync_decode", hs_err, 0);
        chk("small_vsync_decode", vs_err, 0);
        chk("small_video_on_decode", von_err, 0);
        chk("hold_between_ticks", hold_err, 0);
        chk("vsync_low_clks", vs_low, 92);
        chk("video_on_last_visible", c1, 1);
        chk("video_on_x_edge", c2, 0);
        chk("video_on_y_edge", c3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
